// File: rtl/ov7670_capture_ctrl.sv
// OV7670 frame-capture writer.
// Pairs the 8-bit camera byte stream into 16-bit words. Reduces each kept word to a
// 12-bit {R4,G4,B4} pixel. Writes the pixel row-major into a frame buffer, keeping every
// SCALE-th pixel of every SCALE-th line. Capture starts only on a frame boundary, and runs
// either continuously (cap_en) or for a single frame (snap_req).
//
// Ports:
//   pclk, reset_n          sensor pixel clock, asynchronous active-low reset
//   href, v_sync           line valid / vertical blanking from the sensor
//   ov7670_data[7:0]       sensor byte bus
//   cap_en                 continuous capture while high
//   snap_req               single-cycle request for exactly one frame
//   fmt[1:0]               0 RGB565->444, 1 RGB565->332 padded, 2 Y->gray444, 3 as 0
//   we, wAddr, wData       frame-buffer write port
//   busy                   controller is not idle
//   frame_done             one-cycle pulse at the end of each captured frame
//   err_frame              last captured frame had a bad line count or line length
module ov7670_capture_ctrl #(
  parameter int unsigned H_ACTIVE = 640,
  parameter int unsigned V_ACTIVE = 480,
  parameter int unsigned SCALE    = 2,
  parameter int unsigned ADDR_W   = 17
) (
  input  logic              pclk,
  input  logic              reset_n,
  input  logic              href,
  input  logic              v_sync,
  input  logic [7:0]        ov7670_data,
  input  logic              cap_en,
  input  logic              snap_req,
  input  logic [1:0]        fmt,
  output logic              we,
  output logic [ADDR_W-1:0] wAddr,
  output logic [11:0]       wData,
  output logic              busy,
  output logic              frame_done,
  output logic              err_frame
);

  localparam int unsigned LineBytes = 2 * H_ACTIVE;
  // One spare bit so over-long lines saturate well above LineBytes.
  localparam int unsigned BW = $clog2(LineBytes + 1) + 1;
  localparam int unsigned LW = $clog2(V_ACTIVE + 1) + 1;

  typedef enum logic [1:0] {StIdle, StWaitVs, StArm, StActive} state_e;

  state_e              state_q, state_d;
  logic                single_q, single_d;
  logic [1:0]          fmt_q, fmt_d;
  logic                vs_q, vs_prev_q, href_q, href_prev_q;
  logic [7:0]          data_q;
  // High byte minus bit 3, which no output format uses.
  logic [6:0]          hi_q, hi_d;
  logic [BW-1:0]       byte_cnt_q, byte_cnt_d;
  logic [LW-1:0]       line_cnt_q, line_cnt_d;
  logic                line_err_q, line_err_d;
  logic [ADDR_W-1:0]   wptr_q, wptr_d;
  logic                we_q, we_d;
  logic [ADDR_W-1:0]   waddr_q, waddr_d;
  logic [11:0]         wdata_q, wdata_d;
  logic                busy_d, done_d, err_d;
  logic                busy_q, done_q, err_q;

  logic                vs_rise, vs_fall, href_fall;
  logic [BW-1:0]       pix;
  logic                keep;
  logic [11:0]         pix_fmt;
  logic [LW:0]         lines_total;
  logic                cur_line_bad, part_line_bad;

  assign vs_rise   = vs_q & ~vs_prev_q;
  assign vs_fall   = ~vs_q & vs_prev_q;
  assign href_fall = href_prev_q & ~href_q;

  assign pix  = byte_cnt_q >> 1;
  assign keep = href_q & byte_cnt_q[0]
              & ((pix & BW'(SCALE - 1)) == '0)
              & ((line_cnt_q & LW'(SCALE - 1)) == '0)
              & (pix < BW'(H_ACTIVE))
              & (line_cnt_q < LW'(V_ACTIVE));

  // A line closed by href falling in the same cycle as v_sync rising, or still open
  // when v_sync rises, still counts toward the frame check.
  assign lines_total   = {1'b0, line_cnt_q} + (LW + 1)'(href_fall | href_q);
  assign cur_line_bad  = href_fall & (byte_cnt_q != BW'(LineBytes));
  assign part_line_bad = href_q & (({1'b0, byte_cnt_q} + 1'b1) != (BW + 1)'(LineBytes));

  always_comb begin
    unique case (fmt_q)
      2'd1:    pix_fmt = {hi_q[6:4], 1'b0, hi_q[2:0], 1'b0, data_q[4:3], 2'b00};
      2'd2:    pix_fmt = {hi_q[6:3], hi_q[6:3], hi_q[6:3]};
      default: pix_fmt = {hi_q[6:3], hi_q[2:0], data_q[7], data_q[4:1]};
    endcase
  end

  always_comb begin
    state_d    = state_q;
    single_d   = single_q;
    fmt_d      = fmt_q;
    hi_d       = hi_q;
    line_cnt_d = line_cnt_q;
    line_err_d = line_err_q;
    wptr_d     = wptr_q;
    we_d       = 1'b0;
    waddr_d    = waddr_q;
    wdata_d    = wdata_q;
    done_d     = 1'b0;
    err_d      = err_q;

    if (!href_q) begin
      byte_cnt_d = '0;
    end else if (byte_cnt_q != '1) begin
      byte_cnt_d = byte_cnt_q + 1'b1;
    end else begin
      byte_cnt_d = byte_cnt_q;
    end
    if (href_q && !byte_cnt_q[0]) begin
      hi_d = {data_q[7:4], data_q[2:0]};
    end

    unique case (state_q)
      StIdle: begin
        if (cap_en || snap_req) begin
          state_d  = StWaitVs;
          single_d = ~cap_en;
        end
      end
      StWaitVs: begin
        if (vs_rise) state_d = StArm;
      end
      StArm: begin
        if (vs_fall) begin
          state_d    = StActive;
          byte_cnt_d = '0;
          line_cnt_d = '0;
          line_err_d = 1'b0;
          wptr_d     = '0;
          fmt_d      = fmt;
        end
      end
      StActive: begin
        if (vs_rise) begin
          done_d  = 1'b1;
          err_d   = line_err_q | cur_line_bad | part_line_bad
                  | (lines_total != (LW + 1)'(V_ACTIVE));
          state_d = (cap_en && !single_q) ? StArm : StIdle;
        end else begin
          if (href_fall) begin
            if (line_cnt_q != '1) line_cnt_d = line_cnt_q + 1'b1;
            if (cur_line_bad) line_err_d = 1'b1;
          end
          if (keep) begin
            we_d    = 1'b1;
            waddr_d = wptr_q;
            wdata_d = pix_fmt;
            wptr_d  = wptr_q + 1'b1;
          end
        end
      end
      default: state_d = StIdle;
    endcase

    busy_d = (state_d != StIdle);
  end

  always_ff @(posedge pclk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= StIdle;
      single_q    <= 1'b0;
      fmt_q       <= 2'd0;
      vs_q        <= 1'b0;
      vs_prev_q   <= 1'b0;
      href_q      <= 1'b0;
      href_prev_q <= 1'b0;
      data_q      <= 8'd0;
      hi_q        <= 7'd0;
      byte_cnt_q  <= '0;
      line_cnt_q  <= '0;
      line_err_q  <= 1'b0;
      wptr_q      <= '0;
      we_q        <= 1'b0;
      waddr_q     <= '0;
      wdata_q     <= 12'd0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      single_q    <= single_d;
      fmt_q       <= fmt_d;
      vs_q        <= v_sync;
      vs_prev_q   <= vs_q;
      href_q      <= href;
      href_prev_q <= href_q;
      data_q      <= ov7670_data;
      hi_q        <= hi_d;
      byte_cnt_q  <= byte_cnt_d;
      line_cnt_q  <= line_cnt_d;
      line_err_q  <= line_err_d;
      wptr_q      <= wptr_d;
      we_q        <= we_d;
      waddr_q     <= waddr_d;
      wdata_q     <= wdata_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      err_q       <= err_d;
    end
  end

  assign we         = we_q;
  assign wAddr      = waddr_q;
  assign wData      = wdata_q;
  assign busy       = busy_q;
  assign frame_done = done_q;
  assign err_frame  = err_q;

endmodule

// File: tb/tb_ov7670_capture_ctrl.sv
// Bench for ov7670_capture_ctrl on a reduced 8x6 sensor with SCALE=2 (4x3 = 12 pixels/frame).
// Expected writes are derived per frame from the keep/format rules and queued; one
// compare process matches every write and every frame_done against the queues.
module tb_ov7670_capture_ctrl;

  localparam int H  = 8;
  localparam int V  = 6;
  localparam int S  = 2;
  localparam int AW = 8;

  logic          pclk, reset_n, href, v_sync, cap_en, snap_req;
  logic [7:0]    ov_data;
  logic [1:0]    fmt;
  logic          we, busy, frame_done, err_frame;
  logic [AW-1:0] wAddr;
  logic [11:0]   wData;

  ov7670_capture_ctrl #(
    .H_ACTIVE(H), .V_ACTIVE(V), .SCALE(S), .ADDR_W(AW)
  ) dut (
    .pclk(pclk), .reset_n(reset_n), .href(href), .v_sync(v_sync),
    .ov7670_data(ov_data), .cap_en(cap_en), .snap_req(snap_req), .fmt(fmt),
    .we(we), .wAddr(wAddr), .wData(wData), .busy(busy),
    .frame_done(frame_done), .err_frame(err_frame)
  );

  initial begin
    pclk = 1'b0;
    forever #5 pclk = ~pclk;
  end

  logic [19:0] exp_q[$];      // {addr, data}
  bit          exp_err_q[$];
  int          n_checks = 0;
  int          n_fail = 0;
  int          frame_writes = 0;
  int          total_writes = 0;
  logic [11:0] last_data = '0;
  int          last_addr = 0;
  bit          prev_we = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  function automatic logic [11:0] model_pix(input int fm, input logic [7:0] hi,
                                            input logic [7:0] lo);
    int r, g, b;
    if (fm == 1) begin
      r = hi >> 5; g = hi & 7; b = (lo >> 3) & 3;
      return {r[2:0], 1'b0, g[2:0], 1'b0, b[1:0], 2'b00};
    end else if (fm == 2) begin
      r = hi >> 4;
      return {r[3:0], r[3:0], r[3:0]};
    end
    r = hi >> 4; g = ((hi & 7) << 1) | (lo >> 7); b = (lo >> 1) & 15;
    return {r[3:0], g[3:0], b[3:0]};
  endfunction

  function automatic logic [15:0] pix_word(input int pat, input int l, input int p,
                                           input logic [7:0] chi, input logic [7:0] clo);
    logic [7:0] h, lo;
    if (pat == 0) begin
      h = chi; lo = clo;
    end else begin
      h  = 8'((l * 37 + p * 11 + 3) & 255);
      lo = 8'((l * 13 + p * 29 + 91) & 255);
    end
    return {h, lo};
  endfunction

  task automatic tick();
    @(negedge pclk);
  endtask

  always @(negedge pclk) begin
    logic [19:0] e;
    if (reset_n) begin
      if (we) begin
        check("we_gap", prev_we, 0);
        if (exp_q.size() == 0) begin
          n_checks++; n_fail++;
          $display("FAIL unexpected_write: got addr=%0d data=%0h, expected no write (t=%0t)",
                   wAddr, wData, $time);
        end else begin
          e = exp_q.pop_front();
          check("waddr", wAddr, e[19:12]);
          check("wdata", wData, e[11:0]);
        end
        last_addr = wAddr; last_data = wData;
        frame_writes++; total_writes++;
      end
      if (frame_done) begin
        if (exp_err_q.size() == 0) begin
          n_checks++; n_fail++;
          $display("FAIL unexpected_frame_done: got 1, expected 0 (t=%0t)", $time);
        end else begin
          check("err_frame", err_frame, exp_err_q.pop_front());
        end
      end
    end
    prev_we = we;
  end

  // act: 1 raise cap_en, 2 drop cap_en, 3 pulse reset, before line act_line.
  task automatic send_frame(input int nlines, input int short_line, input int short_bytes,
                            input int pat, input logic [7:0] chi, input logic [7:0] clo,
                            input bit capt_in, input int fm, input int act_line, input int act);
    bit capt, bad;
    int exp_addr, nb;
    logic [15:0] w;
    capt = capt_in; exp_addr = 0; frame_writes = 0; bad = (nlines != V);
    fmt = 2'(fm);
    v_sync = 1'b0;
    repeat (4) tick();
    for (int l = 0; l < nlines; l++) begin
      if (l == act_line) begin
        if (act == 1) cap_en = 1'b1;
        else if (act == 2) cap_en = 1'b0;
        else if (act == 3) begin
          check("pre_reset_drain", exp_q.size(), 0);
          reset_n = 1'b0;
          #1;
          check("rst_we", we, 0);
          check("rst_busy", busy, 0);
          check("rst_waddr", wAddr, 0);
          capt = 1'b0;
          exp_q.delete();
          tick(); tick();
          reset_n = 1'b1;
          tick();
        end
      end
      nb = (l == short_line) ? short_bytes : 2 * H;
      if (nb != 2 * H) bad = 1'b1;
      if (capt) begin
        for (int p = 0; 2 * p + 1 < nb; p++) begin
          if (p < H && l < V && p % S == 0 && l % S == 0) begin
            w = pix_word(pat, l, p, chi, clo);
            exp_q.push_back({8'(exp_addr), model_pix(fm, w[15:8], w[7:0])});
            exp_addr++;
          end
        end
      end
      for (int b = 0; b < nb; b++) begin
        w = pix_word(pat, l, b / 2, chi, clo);
        href = 1'b1;
        ov_data = (b % 2 == 1) ? w[7:0] : w[15:8];
        tick();
      end
      href = 1'b0; ov_data = 8'd0;
      repeat (4) tick();
    end
    v_sync = 1'b1;
    if (capt) exp_err_q.push_back(bad);
    repeat (6) tick();
    check("writes_drained", exp_q.size(), 0);
    check("frame_done_seen", exp_err_q.size(), 0);
  endtask

  initial begin
    reset_n = 1'b0; v_sync = 1'b0; href = 1'b0; ov_data = 8'd0;
    cap_en = 1'b0; snap_req = 1'b0; fmt = 2'd0;
    repeat (3) tick();
    check("reset_we", we, 0);
    check("reset_waddr", wAddr, 0);
    check("reset_wdata", wData, 0);
    check("reset_busy", busy, 0);
    check("reset_done", frame_done, 0);
    check("reset_err", err_frame, 0);
    reset_n = 1'b1;
    tick();

    // Continuous capture, armed by a v_sync pulse before the first frame.
    cap_en = 1'b1;
    repeat (2) tick();
    check("busy_wait_vs", busy, 1);
    v_sync = 1'b1;
    repeat (4) tick();
    send_frame(V, -1, 0, 0, 8'hF8, 8'h1F, 1, 0, -1, 0);
    check("f0_writes", frame_writes, 12);
    check("f0_last_addr", last_addr, 11);
    check("f0_last_data", last_data, 12'hF0F);
    send_frame(V, -1, 0, 1, 8'h00, 8'h00, 1, 1, -1, 0);
    send_frame(V, -1, 0, 0, 8'hA5, 8'h5A, 1, 2, -1, 0);
    check("gray_last_data", last_data, 12'hAAA);
    send_frame(V, -1, 0, 1, 8'h00, 8'h00, 1, 3, -1, 0);

    // Frame-shape errors, each followed by a clean frame.
    send_frame(V - 1, -1, 0, 1, 8'h00, 8'h00, 1, 0, -1, 0);
    check("short_frame_err", err_frame, 1);
    send_frame(V, -1, 0, 1, 8'h00, 8'h00, 1, 0, -1, 0);
    check("clean_after_short", err_frame, 0);
    send_frame(V, 2, 2 * H - 2, 1, 8'h00, 8'h00, 1, 0, -1, 0);
    check("short_line_err", err_frame, 1);
    send_frame(V + 1, -1, 0, 1, 8'h00, 8'h00, 1, 0, -1, 0);
    check("long_frame_writes", frame_writes, 12);
    send_frame(V, -1, 0, 1, 8'h00, 8'h00, 1, 0, -1, 0);
    check("clean_after_long", err_frame, 0);

    // Dropping cap_en mid-frame completes that frame, then stops.
    send_frame(V, -1, 0, 1, 8'h00, 8'h00, 1, 1, V - 1, 2);
    send_frame(V, -1, 0, 1, 8'h00, 8'h00, 0, 1, -1, 0);
    check("idle_after_drop", busy, 0);

    // cap_en raised mid-frame: nothing until the next frame, which starts at address 0.
    send_frame(V, -1, 0, 1, 8'h00, 8'h00, 0, 0, 2, 1);
    check("mid_frame_writes", frame_writes, 0);
    send_frame(V, -1, 0, 1, 8'h00, 8'h00, 1, 0, -1, 0);

    // Reset mid-frame: only lines 0 and 2 were written before it.
    send_frame(V, -1, 0, 1, 8'h00, 8'h00, 1, 0, 3, 3);
    check("reset_frame_writes", frame_writes, 8);
    check("err_after_reset", err_frame, 0);
    send_frame(V, -1, 0, 1, 8'h00, 8'h00, 1, 2, V - 1, 2);
    check("idle_after_reset_seq", busy, 0);

    // Snapshot with v_sync already high: skip frame 1, capture frame 2, ignore frame 3.
    tick();
    snap_req = 1'b1;
    tick();
    snap_req = 1'b0;
    tick();
    check("snap_busy", busy, 1);
    total_writes = 0;
    send_frame(V, -1, 0, 1, 8'h00, 8'h00, 0, 0, -1, 0);
    send_frame(V, -1, 0, 1, 8'h00, 8'h00, 1, 1, -1, 0);
    check("snap_idle", busy, 0);
    send_frame(V, -1, 0, 1, 8'h00, 8'h00, 0, 0, -1, 0);
    check("snap_total_writes", total_writes, 12);
    check("snap_still_idle", busy, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
